// File: rtl/count_sequencer_pkg.sv
// count_sequencer_pkg: shared state/opcode encodings and default widths for count_sequencer
package count_sequencer_pkg;
  localparam int CNT_W_DEF = 8;
  localparam int PRE_W_DEF = 4;
  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2} state_e;
  typedef enum logic [1:0] {OP_START = 2'd0, OP_STOP = 2'd1, OP_LOAD = 2'd2, OP_CLEAR = 2'd3} op_e;
endpackage

// File: rtl/count_sequencer_if.sv
// count_sequencer_if: command channel (valid/op/data/prescale from master, ready from slave)
interface count_sequencer_if
  import count_sequencer_pkg::*;
#(
  parameter int CNT_W = CNT_W_DEF,
  parameter int PRE_W = PRE_W_DEF
);
  logic valid;
  logic ready;
  op_e op;
  logic [CNT_W-1:0] data;
  logic [PRE_W-1:0] prescale;
  modport master (output valid, op, data, prescale, input ready);
  modport slave (input valid, op, data, prescale, output ready);
endinterface

// File: rtl/count_sequencer_tick_gen.sv
// tick_gen: prescaler counting 0..pre_q while enabled (clk, rst_n, clear, enable, pre_q in; tick out)
module tick_gen #(
  parameter int PRE_W = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clear,
  input  logic             enable,
  input  logic [PRE_W-1:0] pre_q,
  output logic             tick
);
  logic [PRE_W-1:0] cnt;
  assign tick = enable && cnt == pre_q;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) cnt <= '0;
    else if (clear) cnt <= '0;
    else if (enable) cnt <= tick ? '0 : cnt + 1'b1;
endmodule

// File: rtl/count_sequencer.sv
// count_sequencer: command-driven sequencer for an external counter (cmd channel in; cnt_en/load/clear strobes, busy/done/cmd_err out)
module count_sequencer
  import count_sequencer_pkg::*;
#(
  parameter int CNT_W = CNT_W_DEF,
  parameter int PRE_W = PRE_W_DEF
) (
  input  logic                 clk,
  input  logic                 rst_n,
  count_sequencer_if.slave     cmd,
  input  logic [CNT_W-1:0]     count_in,
  output logic                 cnt_en,
  output logic                 cnt_load,
  output logic [CNT_W-1:0]     cnt_load_val,
  output logic                 cnt_clear,
  output logic                 busy,
  output logic                 done,
  output logic                 cmd_err
);
  localparam logic [1:0] S_IDLE = IDLE;
  localparam logic [1:0] S_RUN  = RUN;
  localparam logic [1:0] S_DONE = DONE;
  logic [1:0] state, state_nx;
  logic [CNT_W-1:0] limit_q;
  logic [PRE_W-1:0] pre_q;
  logic tick, idle, run, acc, stop_acc, at_limit;
  assign idle = state == S_IDLE;
  assign run = state == S_RUN;
  assign cmd.ready = state != S_DONE;
  assign acc = cmd.valid && cmd.ready;
  assign stop_acc = acc && cmd.op == OP_STOP;
  assign at_limit = count_in == limit_q;
  assign cnt_en = run && tick && !at_limit && !stop_acc;
  assign busy = run;
  always_comb
    state_nx = idle ? (acc && cmd.op == OP_START ? S_RUN : S_IDLE)
             : run  ? (stop_acc ? S_IDLE : at_limit ? S_DONE : S_RUN)
             : S_IDLE;
  tick_gen #(.PRE_W(PRE_W)) u_tick (
    .clk    (clk),
    .rst_n  (rst_n),
    .clear  (!run),
    .enable (run),
    .pre_q  (pre_q),
    .tick   (tick)
  );
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= S_IDLE;
      limit_q <= '0;
      pre_q <= '0;
      cnt_load_val <= '0;
      cnt_load <= 1'b0;
      cnt_clear <= 1'b0;
      done <= 1'b0;
      cmd_err <= 1'b0;
    end else begin
      state <= state_nx;
      cnt_load <= acc && idle && cmd.op == OP_LOAD;
      cnt_clear <= acc && idle && cmd.op == OP_CLEAR;
      done <= run && at_limit && !stop_acc;
      cmd_err <= acc && run && cmd.op != OP_STOP;
      if (acc && idle && cmd.op == OP_LOAD) cnt_load_val <= cmd.data;
      if (acc && idle && cmd.op == OP_START) begin
        limit_q <= cmd.data;
        pre_q <= cmd.prescale;
      end
    end
endmodule

// File: tb/tb_count_sequencer.sv
// tb_count_sequencer: scoreboard bench for count_sequencer with an external counter model
module tb_count_sequencer;
  import count_sequencer_pkg::*;
  logic clk = 1'b0;
  logic rst_n = 1'b1;
  logic [7:0] count = 8'h00;
  logic cnt_en, cnt_load, cnt_clear, busy, done, cmd_err;
  logic [7:0] cnt_load_val;
  int n_chk = 0, n_fail = 0;
  int n_en, n_done, n_busy, n_nrdy, n_err, n_ld, done_cyc, err_cyc, nrdy_cyc;
  logic [7:0] got_q[$];
  int cyc_q[$];
  logic [7:0] exp_q[$];
  int exp_cyc[$];
  count_sequencer_if #(.CNT_W(8), .PRE_W(4)) cmd_if ();
  count_sequencer #(.CNT_W(8), .PRE_W(4)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .cmd          (cmd_if),
    .count_in     (count),
    .cnt_en       (cnt_en),
    .cnt_load     (cnt_load),
    .cnt_load_val (cnt_load_val),
    .cnt_clear    (cnt_clear),
    .busy         (busy),
    .done         (done),
    .cmd_err      (cmd_err)
  );
  always #5 clk = ~clk;
  always @(posedge clk)
    count <= cnt_clear ? 8'h00 : cnt_load ? cnt_load_val : cnt_en ? count + 8'h01 : count;
  task automatic send(input op_e op, input logic [7:0] data, input logic [3:0] pre);
    @(posedge clk);
    #1;
    cmd_if.valid = 1'b1;
    cmd_if.op = op;
    cmd_if.data = data;
    cmd_if.prescale = pre;
    @(posedge clk);
    #1;
    cmd_if.valid = 1'b0;
  endtask
  task automatic observe(input int n);
    n_en = 0; n_done = 0; n_busy = 0; n_nrdy = 0; n_err = 0; n_ld = 0;
    done_cyc = -1; err_cyc = -1; nrdy_cyc = -1;
    got_q.delete();
    cyc_q.delete();
    for (int c = 1; c <= n; c++) begin
      @(negedge clk);
      if (cnt_en) begin n_en++; got_q.push_back(count); cyc_q.push_back(c); end
      if (done) begin n_done++; done_cyc = c; end
      if (busy) n_busy++;
      if (!cmd_if.ready) begin n_nrdy++; nrdy_cyc = c; end
      if (cmd_err) begin n_err++; err_cyc = c; end
      if (cnt_load || cnt_clear) n_ld++;
    end
  endtask
  task automatic test_reset();
    cmd_if.valid = 1'b0;
    cmd_if.op = OP_STOP;
    cmd_if.data = '0;
    cmd_if.prescale = '0;
    #2 rst_n = 1'b0;
    #1;
    n_chk++; if (cmd_if.ready !== 1'b1) begin n_fail++; $display("FAIL reset_ready: got %b want 1", cmd_if.ready); end
    n_chk++; if ({busy, cnt_en, cnt_load, cnt_clear, done, cmd_err} !== 6'b0) begin n_fail++; $display("FAIL reset_strobes: got %b want 000000", {busy, cnt_en, cnt_load, cnt_clear, done, cmd_err}); end
    n_chk++; if (cnt_load_val !== 8'h00) begin n_fail++; $display("FAIL reset_load_val: got %h want 00", cnt_load_val); end
    @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    n_chk++; if (cmd_if.ready !== 1'b1) begin n_fail++; $display("FAIL post_reset_ready: got %b want 1", cmd_if.ready); end
  endtask
  task automatic test_idle_cmds();
    send(OP_LOAD, 8'h33, 4'd0);
    @(negedge clk);
    n_chk++; if ({cnt_load, cnt_clear, cnt_load_val} !== {2'b10, 8'h33}) begin n_fail++; $display("FAIL idle_load: got ld=%b clr=%b val=%h want ld=1 clr=0 val=33", cnt_load, cnt_clear, cnt_load_val); end
    @(negedge clk);
    n_chk++; if ({cnt_load, count} !== {1'b0, 8'h33}) begin n_fail++; $display("FAIL idle_load_after: got ld=%b count=%h want ld=0 count=33", cnt_load, count); end
    send(OP_CLEAR, 8'hAA, 4'd0);
    @(negedge clk);
    n_chk++; if ({cnt_clear, cnt_load} !== 2'b10) begin n_fail++; $display("FAIL idle_clear: got clr=%b ld=%b want clr=1 ld=0", cnt_clear, cnt_load); end
    @(negedge clk);
    n_chk++; if ({cnt_clear, count} !== {1'b0, 8'h00}) begin n_fail++; $display("FAIL idle_clear_after: got clr=%b count=%h want clr=0 count=00", cnt_clear, count); end
    send(OP_STOP, 8'h00, 4'd0);
    observe(3);
    n_chk++; if (n_err != 0 || n_busy != 0 || n_en != 0) begin n_fail++; $display("FAIL idle_stop: got err=%0d busy=%0d en=%0d want 0 0 0", n_err, n_busy, n_en); end
  endtask
  task automatic test_load_run();
    logic [7:0] e, g;
    int ec, gc;
    send(OP_LOAD, 8'h10, 4'd0);
    send(OP_START, 8'h14, 4'd0);
    for (int i = 0; i < 4; i++) begin exp_q.push_back(8'h10 + 8'(i)); exp_cyc.push_back(i + 1); end
    observe(8);
    n_chk++; if (n_en != 4) begin n_fail++; $display("FAIL load_run_en_count: got %0d want 4", n_en); end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); ec = exp_cyc.pop_front();
      g = got_q.size() > 0 ? got_q.pop_front() : 8'hxx; gc = cyc_q.size() > 0 ? cyc_q.pop_front() : -1;
      n_chk++; if (g !== e || gc != ec) begin n_fail++; $display("FAIL load_run_en: got count=%h cyc=%0d want count=%h cyc=%0d", g, gc, e, ec); end
    end
    n_chk++; if (n_done != 1 || done_cyc != 6) begin n_fail++; $display("FAIL load_run_done: got n=%0d cyc=%0d want n=1 cyc=6", n_done, done_cyc); end
    n_chk++; if (count !== 8'h14 || busy !== 1'b0 || n_busy != 5) begin n_fail++; $display("FAIL load_run_end: got count=%h busy=%b nbusy=%0d want 14 0 5", count, busy, n_busy); end
  endtask
  task automatic test_prescale();
    logic [7:0] e, g;
    int ec, gc;
    send(OP_CLEAR, 8'h00, 4'd0);
    send(OP_START, 8'h03, 4'd3);
    for (int i = 0; i < 3; i++) begin exp_q.push_back(8'(i)); exp_cyc.push_back(4 * i + 4); end
    observe(16);
    n_chk++; if (n_en != 3) begin n_fail++; $display("FAIL prescale_en_count: got %0d want 3", n_en); end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); ec = exp_cyc.pop_front();
      g = got_q.size() > 0 ? got_q.pop_front() : 8'hxx; gc = cyc_q.size() > 0 ? cyc_q.pop_front() : -1;
      n_chk++; if (g !== e || gc != ec) begin n_fail++; $display("FAIL prescale_en: got count=%h cyc=%0d want count=%h cyc=%0d", g, gc, e, ec); end
    end
    n_chk++; if (n_done != 1 || done_cyc != 14 || count !== 8'h03) begin n_fail++; $display("FAIL prescale_done: got n=%0d cyc=%0d count=%h want 1 14 03", n_done, done_cyc, count); end
  endtask
  task automatic test_wrap();
    logic [7:0] e, g;
    int ec, gc;
    send(OP_LOAD, 8'hFE, 4'd0);
    send(OP_START, 8'h01, 4'd0);
    exp_q.push_back(8'hFE); exp_q.push_back(8'hFF); exp_q.push_back(8'h00);
    for (int i = 1; i <= 3; i++) exp_cyc.push_back(i);
    observe(7);
    n_chk++; if (n_en != 3) begin n_fail++; $display("FAIL wrap_en_count: got %0d want 3", n_en); end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); ec = exp_cyc.pop_front();
      g = got_q.size() > 0 ? got_q.pop_front() : 8'hxx; gc = cyc_q.size() > 0 ? cyc_q.pop_front() : -1;
      n_chk++; if (g !== e || gc != ec) begin n_fail++; $display("FAIL wrap_en: got count=%h cyc=%0d want count=%h cyc=%0d", g, gc, e, ec); end
    end
    n_chk++; if (n_done != 1 || done_cyc != 5 || count !== 8'h01) begin n_fail++; $display("FAIL wrap_done: got n=%0d cyc=%0d count=%h want 1 5 01", n_done, done_cyc, count); end
  endtask
  task automatic test_stop_err();
    logic [7:0] e, g;
    int ec, gc;
    send(OP_CLEAR, 8'h00, 4'd0);
    send(OP_START, 8'h80, 4'd0);
    for (int i = 0; i < 5; i++) begin exp_q.push_back(8'(i)); exp_cyc.push_back(i + 1); end
    fork
      observe(10);
      begin
        cmd_if.valid = 1'b1; cmd_if.op = OP_LOAD; cmd_if.data = 8'h55;
        @(posedge clk);
        #1 cmd_if.valid = 1'b0;
        repeat (4) @(posedge clk);
        #1 cmd_if.valid = 1'b1; cmd_if.op = OP_STOP;
        @(posedge clk);
        #1 cmd_if.valid = 1'b0;
      end
    join
    n_chk++; if (n_en != 5) begin n_fail++; $display("FAIL stop_en_count: got %0d want 5", n_en); end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); ec = exp_cyc.pop_front();
      g = got_q.size() > 0 ? got_q.pop_front() : 8'hxx; gc = cyc_q.size() > 0 ? cyc_q.pop_front() : -1;
      n_chk++; if (g !== e || gc != ec) begin n_fail++; $display("FAIL stop_en: got count=%h cyc=%0d want count=%h cyc=%0d", g, gc, e, ec); end
    end
    n_chk++; if (n_done != 0 || count !== 8'h05 || n_busy != 6 || busy !== 1'b0) begin n_fail++; $display("FAIL stop_end: got done=%0d count=%h nbusy=%0d busy=%b want 0 05 6 0", n_done, count, n_busy, busy); end
    n_chk++; if (n_err != 1 || err_cyc != 2 || n_ld != 0) begin n_fail++; $display("FAIL run_load_err: got n=%0d cyc=%0d ld=%0d want 1 2 0", n_err, err_cyc, n_ld); end
  endtask
  task automatic test_reset_mid_run();
    send(OP_CLEAR, 8'h00, 4'd0);
    send(OP_START, 8'h80, 4'd0);
    repeat (3) @(negedge clk);
    n_chk++; if ({busy, cnt_en} !== 2'b11) begin n_fail++; $display("FAIL pre_reset_run: got busy=%b en=%b want 1 1", busy, cnt_en); end
    #1 rst_n = 1'b0;
    #1;
    n_chk++; if ({busy, cnt_en} !== 2'b00) begin n_fail++; $display("FAIL async_reset_drop: got busy=%b en=%b want 0 0", busy, cnt_en); end
    @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    n_chk++; if ({cmd_if.ready, busy, cnt_load, cnt_clear, done, cmd_err} !== 6'b100000 || cnt_load_val !== 8'h00) begin n_fail++; $display("FAIL post_run_reset: got rdy/busy/ld/clr/done/err=%b val=%h want 100000 00", {cmd_if.ready, busy, cnt_load, cnt_clear, done, cmd_err}, cnt_load_val); end
  endtask
  task automatic test_equal();
    send(OP_LOAD, 8'h07, 4'd0);
    send(OP_START, 8'h07, 4'd0);
    observe(5);
    n_chk++; if (n_en != 0 || n_busy != 1) begin n_fail++; $display("FAIL equal_run: got en=%0d busy=%0d want 0 1", n_en, n_busy); end
    n_chk++; if (n_done != 1 || done_cyc != 2) begin n_fail++; $display("FAIL equal_done: got n=%0d cyc=%0d want 1 2", n_done, done_cyc); end
    n_chk++; if (n_nrdy != 1 || nrdy_cyc != 2) begin n_fail++; $display("FAIL equal_ready: got n=%0d cyc=%0d want 1 2", n_nrdy, nrdy_cyc); end
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end
  initial begin
    test_reset();
    test_idle_cmds();
    test_load_run();
    test_prescale();
    test_wrap();
    test_stop_err();
    test_reset_mid_run();
    test_equal();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/count_sequencer.md
COUNT_SEQUENCER -- requirements
Module: count_sequencer

Interface
REQ-001 Parameter CNT_W, default 8: width of the sequenced counter value, limit and load data.
REQ-002 Parameter PRE_W, default 4: width of the prescale field.
REQ-003 Port clk input 1: single clock; all state updates on its rising edge.
REQ-004 Port rst_n input 1: reset, asynchronous, active-low.
REQ-005 Port cmd_valid input 1: command request.
REQ-006 Port cmd_op input 2: opcode; 0=START, 1=STOP, 2=LOAD, 3=CLEAR.
REQ-007 Port cmd_data input CNT_W: load value for LOAD, limit for START.
REQ-008 Port cmd_prescale input PRE_W: tick divider for START; one tick every cmd_prescale+1 cycles.
REQ-009 Port cmd_ready output 1: command accepted when cmd_valid and cmd_ready are both high.
REQ-010 Port count_in input CNT_W: current value fed back from the external counter datapath.
REQ-011 Port cnt_en output 1: increment strobe to the counter.
REQ-012 Port cnt_load output 1: load strobe; cnt_load_val is the value to load.
REQ-013 Port cnt_load_val output CNT_W: registered load value.
REQ-014 Port cnt_clear output 1: synchronous clear strobe to the counter.
REQ-015 Port busy output 1: high in RUN.
REQ-016 Port done output 1: one-cycle pulse on reaching the limit.
REQ-017 Port cmd_err output 1: one-cycle pulse when an accepted command is dropped.

Function
REQ-018 FSM states IDLE, RUN, DONE; encoding from the shared package.
REQ-019 cmd_ready SHALL be high in IDLE and RUN, low in DONE.
REQ-020 IDLE+START accepted: latch limit_q=cmd_data and pre_q=cmd_prescale, clear prescaler, go to RUN next cycle.
REQ-021 IDLE+LOAD accepted: cnt_load=1 and cnt_load_val=cmd_data in the next cycle only; state stays IDLE.
REQ-022 IDLE+CLEAR accepted: cnt_clear=1 in the next cycle only; state stays IDLE.
REQ-023 IDLE+STOP accepted: no-op, no cmd_err.
REQ-024 RUN: prescaler counts 0..pre_q and wraps to 0; tick is true when prescaler==pre_q; pre_q=0 gives a tick every cycle.
REQ-025 cnt_en SHALL be combinational: (state==RUN) and tick and (count_in != limit_q) and not (cmd accepted with STOP).
REQ-026 RUN with count_in==limit_q: go to DONE next cycle with no cnt_en; done=1 during the DONE cycle; DONE returns to IDLE after exactly one cycle.
REQ-027 RUN+STOP accepted: go to IDLE next cycle; no done; STOP takes priority over limit detection in the same cycle.
REQ-028 RUN+START, LOAD or CLEAR accepted: command dropped; cmd_err=1 next cycle; RUN continues unaffected.
REQ-029 Wrap-around: limit_q < count_in at START is legal; the counter wraps through 2^CNT_W-1 to 0 and stops at limit_q.
REQ-030 count_in==limit_q at START: exactly one RUN cycle, zero cnt_en, then DONE.
REQ-031 cnt_load, cnt_clear, done and cmd_err SHALL be registered; busy decodes directly from the state register.

Reset
REQ-032 rst_n low SHALL immediately force state=IDLE, prescaler=0, limit_q=0, pre_q=0, cnt_load_val=0 and cnt_load=cnt_clear=done=cmd_err=0.
REQ-033 Reset asserted mid-RUN SHALL drop cnt_en and busy within the same cycle, without waiting for a clock edge.
REQ-034 cmd_ready SHALL be high in the first cycle after reset release (IDLE).

Structure
REQ-035 A shared package SHALL hold the state enum (IDLE, RUN, DONE), the opcode enum and CNT_W/PRE_W defaults.
REQ-036 One sub-module, tick_gen, SHALL hold the PRE_W prescaler; it takes clear, enable and pre_q and outputs tick.
REQ-037 The counter itself is external; the top-level wrapper connects count_in, cnt_en, cnt_load and cnt_clear to it.

Verification
REQ-038 LOAD data=0x10, then START data=0x14 prescale=0 -> cnt_en on 4 consecutive cycles, count reaches 0x14, one done pulse, then IDLE.
REQ-039 count=0, START data=0x03 prescale=3 -> cnt_en exactly once every 4 cycles, 3 pulses total, done 1 cycle after count==3.
REQ-040 count=0xFE, START data=0x01 prescale=0 -> count goes 0xFF, 0x00, 0x01, then done; 3 cnt_en total.
REQ-041 START data=0x80 prescale=0, STOP after 5 cnt_en -> count=5, no done, IDLE next cycle; LOAD sent during RUN -> cmd_err pulse, count unaffected.
REQ-042 rst_n low mid-RUN -> cnt_en and busy low in the same cycle; after release cmd_ready=1 and all strobes 0.
REQ-043 count=0x07, START data=0x07 -> zero cnt_en; done asserted 2 cycles after acceptance; cmd_ready low only in the DONE cycle.
